// File: rtl/alu_cmd_sequencer_if.sv
// Bundled command, ALU and response signals of the ALU command sequencer.
// The sequencer connects through slave; the command source, ALU and response sink through master.
interface alu_cmd_sequencer_if #(
    parameter int unsigned TAG_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_opcode;
    logic             alu_enable;
    logic [31:0]      alu_result;
    logic             alu_ack;

    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;
    logic             busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output alu_a, alu_b, alu_opcode, alu_enable,
        input  alu_result, alu_ack,
        output res_valid, res_data, res_tag, res_err,
        input  res_ready,
        output busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  alu_a, alu_b, alu_opcode, alu_enable,
        output alu_result, alu_ack,
        input  res_valid, res_data, res_tag, res_err,
        output res_ready,
        input  busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues tagged ALU commands, issues them one at a time to a combinational ALU
// and returns each result (or a timeout abort) with its tag on a valid/ready channel.
module alu_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cmd_sequencer_if.slave  bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);
    localparam int unsigned DW  = 32;
    localparam int unsigned OPW = 3;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [OPW-1:0]   op;
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state_q, state_d;
    cmd_t             mem [DEPTH];
    cmd_t             cur_q;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      fifo_count;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full, empty, push, pop, capture, abort;
    logic             res_valid_q, res_err_q;
    logic [DW-1:0]    res_data_q;
    logic [TAG_W-1:0] res_tag_q;

    assign full  = (fifo_count == (AW+1)'(DEPTH));
    assign empty = (fifo_count == '0);
    assign push  = bus.cmd_valid && !full;

    // Next-state and per-cycle control decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        capture = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.alu_ack) begin
                    capture = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (res_valid_q && bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{tag: bus.cmd_tag, op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // In-flight command and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q       <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            res_tag_q   <= '0;
        end else begin
            if (pop) cur_q <= mem[rd_ptr];
            if (capture || abort) begin
                res_valid_q <= 1'b1;
                res_err_q   <= abort;
                res_data_q  <= capture ? bus.alu_result : '0;
                res_tag_q   <= cur_q.tag;
            end else if (res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready  = !full;
    assign bus.alu_a      = cur_q.a;
    assign bus.alu_b      = cur_q.b;
    assign bus.alu_opcode = cur_q.op;
    assign bus.alu_enable = (state_q == ISSUE);
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.res_err    = res_err_q;
    assign bus.busy       = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural ALU whose ack timing is selectable.
module tb_alu_cmd_sequencer;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   ack_mode = 0;     // 0: ack at once, 1: never ack, 2: ack on 3rd enabled cycle
    int   en_run = 0;
    int   en_total = 0;
    int   n_acc = 0;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    alu_cmd_sequencer_if #(.TAG_W(4)) bus ();

    alu_cmd_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << b[4:0];
            default: return b;
        endcase
    endfunction

    assign bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);
    assign bus.alu_ack    = (ack_mode == 0) ? bus.alu_enable :
                            (ack_mode == 2) ? (bus.alu_enable && en_run == 2) : 1'b0;

    always @(posedge clk) en_run <= bus.alu_enable ? en_run + 1 : 0;
    always @(negedge clk) if (bus.alu_enable) en_total <= en_total + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Response monitor: every accepted response must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_res", 32'(bus.res_tag), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check_eq("res_data", bus.res_data, mon_e.data);
                check_eq("res_tag", 32'(bus.res_tag), 32'(mon_e.tag));
                check_eq("res_err", 32'(bus.res_err), 32'(mon_e.err));
            end
        end
    end

    // Enters and leaves at posedge+1
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input logic err);
        int   n;
        exp_t e;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            check_eq("send_timeout", 32'(n), 32'd0);
            bus.cmd_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            e.data = err ? 32'd0 : alu_fn(a, b, op);
            e.tag  = tag;
            e.err  = err;
            sb.push_back(e);
            n_acc++;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_timeout", 32'(n >= 500), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        int n;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
        bus.res_ready = 1'b1;
        #3;
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
        check_eq("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_eq("rst_res_data", bus.res_data, 32'd0);
        check_eq("rst_res_tag_err", 32'({bus.res_tag, bus.res_err}), 32'd0);
        check_eq("rst_alu_ops", 32'(bus.alu_a | bus.alu_b | 32'(bus.alu_opcode)), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Single op latency and one-cycle enable
        base = en_total;
        send(32'h5, 32'h3, 3'd0, 4'd1, 1'b0);
        @(negedge clk);
        check_eq("lat_k0_enable", 32'(bus.alu_enable), 32'd0);
        check_eq("lat_k0_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_k1_enable", 32'(bus.alu_enable), 32'd1);
        check_eq("lat_k1_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check_eq("lat_k2_valid", 32'(bus.res_valid), 32'd1);
        check_eq("lat_k2_data", bus.res_data, 32'h8);
        wait_drain();
        check_eq("single_enable_cycles", 32'(en_total - base), 32'd1);

        // Fill with backpressure
        bus.res_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(32'h10, 32'h20, 3'd0, 4'd0, 1'b0);
                send(32'h0, 32'h1, 3'd1, 4'd1, 1'b0);
                send(32'h0, 32'h1234, 3'd5, 4'd2, 1'b0);
                send(32'hF0F0_1234, 32'h0FF0_FF00, 3'd2, 4'd3, 1'b0);
                send(32'hAAAA_5555, 32'hFFFF_0000, 3'd4, 4'd4, 1'b0);
                send(32'h1, 32'd31, 3'd6, 4'd5, 1'b0);
            end
            begin
                n = 0;
                while (bus.cmd_ready && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check_eq("fill_accepted_at_full", 32'(n_acc), 32'd5);
                repeat (3) @(negedge clk);
                check_eq("fill_ready_held_low", 32'(bus.cmd_ready), 32'd0);
                check_eq("fill_busy", 32'(bus.busy), 32'd1);
                check_eq("fill_res_tag_held", 32'(bus.res_tag), 32'd0);
                @(posedge clk); #1;
                bus.res_ready = 1'b1;
            end
        join
        wait_drain();

        // Timeout abort, then a normal command
        ack_mode = 1;
        base = en_total;
        send(32'h11, 32'h22, 3'd0, 4'd7, 1'b1);
        wait_drain();
        check_eq("timeout_enable_cycles", 32'(en_total - base), 32'd8);
        ack_mode = 0;
        send(32'h100, 32'h1, 3'd1, 4'd8, 1'b0);
        wait_drain();

        // Delayed ack with operand stability
        ack_mode = 2;
        base = en_total;
        send(32'hDEAD_BEEF, 32'h0000_FFFF, 3'd3, 4'd9, 1'b0);
        n = 0;
        while (!bus.res_valid && n < 30) begin
            @(negedge clk);
            if (bus.alu_enable) begin
                check_eq("stable_alu_a", bus.alu_a, 32'hDEAD_BEEF);
                check_eq("stable_alu_b", bus.alu_b, 32'h0000_FFFF);
                check_eq("stable_alu_op", 32'(bus.alu_opcode), 32'd3);
            end
            n++;
        end
        wait_drain();
        check_eq("delayed_enable_cycles", 32'(en_total - base), 32'd3);
        ack_mode = 0;

        // Simultaneous push and pop keep the count
        bus.res_ready = 1'b0;
        send(32'h1, 32'h2, 3'd0, 4'd10, 1'b0);
        send(32'h3, 32'h4, 3'd4, 4'd11, 1'b0);
        send(32'h5, 32'h6, 3'd7, 4'd12, 1'b0);
        check_eq("pp_count_before", 32'(dut.fifo_count), 32'd2);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h7, 32'h8, 3'd2, 4'd13, 1'b0);
        @(negedge clk);
        check_eq("pp_count_after", 32'(dut.fifo_count), 32'd2);
        wait_drain();

        // Async reset mid-op with three queued
        ack_mode = 1;
        send(32'hA, 32'hB, 3'd0, 4'd1, 1'b1);
        send(32'hC, 32'hD, 3'd0, 4'd2, 1'b0);
        send(32'hE, 32'hF, 3'd0, 4'd3, 1'b0);
        send(32'h1, 32'h1, 3'd0, 4'd4, 1'b0);
        check_eq("mid_enable_before_rst", 32'(bus.alu_enable), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_enable", 32'(bus.alu_enable), 32'd0);
        check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_eq("mid_rst_alu_a", bus.alu_a, 32'd0);
        sb.delete();
        ack_mode = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("post_rst_busy", 32'(bus.busy), 32'd0);
        check_eq("post_rst_res_valid", 32'(bus.res_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got=running expected=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 32-bit combinational ALU (opcode/enable in, result/ack out).
- Buffers tagged operation commands in a small FIFO and issues them to the ALU one at a time, with `alu_enable` held only while a command is in flight.
- Captures the ALU result when `alu_ack` is asserted and returns it, with its tag, on a valid/ready response channel.
- Guards against a missing ack with a cycle timeout.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TAG_W, 4, width of the command tag returned with each result
- TIMEOUT, 8, cycles `alu_enable` may stay high without `alu_ack` before the command is aborted (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept (= not full)
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_op  in  3  ALU opcode
- cmd_tag  in  TAG_W  command tag
- alu_a  out  32  operand A to ALU
- alu_b  out  32  operand B to ALU
- alu_opcode  out  3  opcode to ALU
- alu_enable  out  1  ALU enable
- alu_result  in  32  ALU result
- alu_ack  in  1  ALU acknowledge
- res_valid  out  1  response present
- res_ready  in  1  downstream accepts response
- res_data  out  32  captured result
- res_tag  out  TAG_W  tag of the completed command
- res_err  out  1  1 = timeout abort, `res_data` = 0
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset: asynchronous on `rst_n` low; takes effect immediately, not at the next edge.
  - FIFO empty, FSM IDLE, timeout counter 0.
  - `alu_a`/`alu_b`/`alu_opcode` = 0; `alu_enable`, `res_valid`, `res_err`, `busy` = 0; `res_data`/`res_tag` = 0; `cmd_ready` = 1.
  - Reset mid-operation discards all queued and in-flight commands; `alu_enable` drops at once.
- FIFO:
  - Push on `cmd_valid & cmd_ready`.
  - `cmd_ready` = !full, from the registered count; no combinational path from `res_ready`.
  - Pop only in IDLE when non-empty.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - No bypass: a command written at edge k is visible to the FSM only after edge k.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop the head into the operand/opcode/tag registers, clear the counter, go to ISSUE.
  - ISSUE:
    - `alu_enable` = 1; `alu_a`/`alu_b`/`alu_opcode` are driven from the registers, stable for the whole state.
    - If `alu_ack` = 1 at the edge: `res_data` <= `alu_result`, `res_tag` <= tag, `res_err` <= 0, `res_valid` <= 1, go to RESP.
    - Else increment the counter. When the counter reaches TIMEOUT−1 with no ack: `res_data` <= 0, `res_err` <= 1, `res_valid` <= 1, go to RESP. `alu_enable` is therefore high for exactly TIMEOUT cycles.
  - RESP:
    - `alu_enable` = 0; operand outputs hold their last values.
    - Response fields are stable while `res_valid` & !`res_ready`.
    - On `res_valid & res_ready`: `res_valid` <= 0, go to IDLE.
- Latency: with an empty FIFO, IDLE, and the ALU acking combinationally, a command accepted at edge k is popped at edge k+1 and captured at edge k+2. `res_valid` rises after edge k+2.
- Throughput: one command per 3 cycles with `res_ready` held high.
- Ordering: responses are returned strictly in command order.
- `alu_ack` is ignored outside ISSUE.
- Arithmetic is owned by the ALU; the sequencer never modifies data.

Test Plan:
- Single op: reset, push A=0x0000_0005, B=0x0000_0003, op=000, tag=1; ALU model acks same cycle → `res_valid` 2 cycles after accept, `res_data`=0x0000_0008, `res_tag`=1, `res_err`=0; `alu_enable` high exactly 1 cycle.
- Fill/backpressure: hold `res_ready`=0 and push 6 commands (tags 0–5) → `cmd_ready` drops after 4 FIFO entries plus 1 in flight; releasing `res_ready` returns tags 0–5 in order with correct results (include op=001 0x0−0x1=0xFFFF_FFFF and op=101 ~0x0=0xFFFF_FFFF).
- Timeout: ALU model never acks, push tag=7 → `alu_enable` high exactly 8 cycles, then `res_valid`=1, `res_err`=1, `res_data`=0, `res_tag`=7; the next command proceeds normally.
- Delayed ack: ack on the 3rd ISSUE cycle → result captured then; `alu_a`/`alu_b`/`alu_opcode` stable throughout ISSUE; `res_err`=0.
- Simultaneous push/pop: with FIFO count=2, push in the same cycle as an IDLE pop → count stays 2; no command lost or duplicated.
- Async reset mid-op: assert `rst_n`=0 during ISSUE with 3 queued → outputs go to reset values immediately without a clock edge; after release `busy`=0 and no stale response appears.
